// File: rtl/param_register_file_if.sv
// Register file bus: read ports, WB write port and ID issue port.
//
// Signals (directions as seen by the register file, the slave):
//   reg_write    in   write enable from WB
//   write_reg    in   write index
//   write_data   in   write value
//   read_reg_1   in   read index, port 1
//   read_reg_2   in   read index, port 2
//   read_data_1  out  read value, port 1
//   read_data_2  out  read value, port 2
//   issue_valid  in   ID issues an instruction that will write issue_reg
//   issue_reg    in   destination of the issued instruction
//   busy_1       out  read_reg_1 has an outstanding producer
//   busy_2       out  read_reg_2 has an outstanding producer
interface param_register_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_reg_1;
    logic [ADDR_WIDTH-1:0] read_reg_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_reg;
    logic                  busy_1;
    logic                  busy_2;

    modport master (
        output reg_write, write_reg, write_data,
        output read_reg_1, read_reg_2,
        output issue_valid, issue_reg,
        input  read_data_1, read_data_2, busy_1, busy_2
    );

    modport slave (
        input  reg_write, write_reg, write_data,
        input  read_reg_1, read_reg_2,
        input  issue_valid, issue_reg,
        output read_data_1, read_data_2, busy_1, busy_2
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised two-read/one-write register file for the ID stage, with an
// optional hardwired-zero register 0, optional write-to-read forwarding and
// a per-register busy bit used by decode to detect RAW hazards.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset; clears all registers and busy bits
//   bus  param_register_file_if slave modport (read, write and issue ports)
//
// Reads are purely combinational from index to data and busy.
module param_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    param_register_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]      busy_r;

    logic                  write_en_s;
    logic [DEPTH-1:0]      busy_set_s;
    logic [DEPTH-1:0]      busy_clr_s;
    logic [DATA_WIDTH:0]   port_1_s;
    logic [DATA_WIDTH:0]   port_2_s;

    // One read port: returns {busy, data}. Register 0 (when hardwired)
    // wins over forwarding; a forwarded value is never reported busy.
    function automatic logic [DATA_WIDTH:0] read_mux(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  stored_busy,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd
    );
        logic [DATA_WIDTH:0] res;
        if (ZERO_REG && (addr == ZERO_IDX)) begin
            res = {1'b0, {DATA_WIDTH{1'b0}}};
        end else if (BYPASS && we && (wa == addr)) begin
            res = {1'b0, wd};
        end else begin
            res = {stored_busy, stored};
        end
        return res;
    endfunction

    // Write qualification and one-hot busy set/clear decode.
    always_comb begin
        write_en_s = 1'b0;
        busy_set_s = {DEPTH{1'b0}};
        busy_clr_s = {DEPTH{1'b0}};
        if (bus.reg_write && !(ZERO_REG && (bus.write_reg == ZERO_IDX))) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
        if (bus.reg_write) begin
            busy_clr_s[bus.write_reg] = 1'b1;
        end else begin
            busy_clr_s = {DEPTH{1'b0}};
        end
        if (bus.issue_valid && !(ZERO_REG && (bus.issue_reg == ZERO_IDX))) begin
            busy_set_s[bus.issue_reg] = 1'b1;
        end else begin
            busy_set_s = {DEPTH{1'b0}};
        end
    end

    // Register array and busy vector; set is applied after clear so a new
    // producer issuing against a writing-back register keeps it busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (write_en_s) begin
                regs_r[bus.write_reg] <= bus.write_data;
            end
            busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
        end
    end

    // Combinational read ports.
    always_comb begin
        port_1_s = read_mux(bus.read_reg_1, regs_r[bus.read_reg_1], busy_r[bus.read_reg_1],
                            bus.reg_write, bus.write_reg, bus.write_data);
        port_2_s = read_mux(bus.read_reg_2, regs_r[bus.read_reg_2], busy_r[bus.read_reg_2],
                            bus.reg_write, bus.write_reg, bus.write_data);
    end

    assign bus.read_data_1 = port_1_s[DATA_WIDTH-1:0];
    assign bus.busy_1      = port_1_s[DATA_WIDTH];
    assign bus.read_data_2 = port_2_s[DATA_WIDTH-1:0];
    assign bus.busy_2      = port_2_s[DATA_WIDTH];
endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file. Three instances share one stimulus stream:
//   0: 16-bit x 8,  ZERO_REG=1, BYPASS=1
//   1: 16-bit x 8,  ZERO_REG=0, BYPASS=0
//   2: 32-bit x 32, ZERO_REG=1, BYPASS=1
// A driver applies each cycle's inputs, pushes the expected outputs from a
// behavioural model into a per-instance queue, and a monitor on the falling
// edge pops and compares.
module tb_param_register_file;
    logic clk;
    logic rst;

    param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if_a ();
    param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if_b ();
    param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_c ();

    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b0), .BYPASS(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    typedef struct packed {
        bit          chk;
        logic [31:0] d1;
        logic [31:0] d2;
        bit          b1;
        bit          b2;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // Reference model: plain arrays updated by the architectural rules.
    logic [31:0] m_regs [3][32];
    bit          m_busy [3][32];
    bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
    bit          byp [3] = '{1'b1, 1'b0, 1'b1};

    int vectors     = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void pred_port(input int k, input int r, input bit we, input int wr,
                                      input logic [31:0] wd,
                                      output logic [31:0] d, output bit b);
        if (zr[k] && r == 0) begin
            d = 32'h0; b = 1'b0;
        end else if (byp[k] && we && wr == r) begin
            d = wd; b = 1'b0;
        end else begin
            d = m_regs[k][r]; b = m_busy[k][r];
        end
    endfunction

    function automatic void model_edge(input int k, input bit rs, input bit we, input int wr,
                                       input logic [31:0] wd, input bit iv, input int ir);
        if (rs) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[k][i] = 32'h0;
                m_busy[k][i] = 1'b0;
            end
        end else begin
            if (we && !(zr[k] && wr == 0)) m_regs[k][wr] = wd;
            if (we) m_busy[k][wr] = 1'b0;
            if (iv && !(zr[k] && ir == 0)) m_busy[k][ir] = 1'b1;
        end
    endfunction

    task automatic step(input bit rs, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input bit iv, input logic [4:0] ir);
        @(posedge clk);
        #1;
        rst = rs;
        if_a.reg_write = we; if_a.write_reg = wr[2:0]; if_a.write_data = wd[15:0];
        if_a.read_reg_1 = r1[2:0]; if_a.read_reg_2 = r2[2:0];
        if_a.issue_valid = iv; if_a.issue_reg = ir[2:0];
        if_b.reg_write = we; if_b.write_reg = wr[2:0]; if_b.write_data = wd[15:0];
        if_b.read_reg_1 = r1[2:0]; if_b.read_reg_2 = r2[2:0];
        if_b.issue_valid = iv; if_b.issue_reg = ir[2:0];
        if_c.reg_write = we; if_c.write_reg = wr; if_c.write_data = wd;
        if_c.read_reg_1 = r1; if_c.read_reg_2 = r2;
        if_c.issue_valid = iv; if_c.issue_reg = ir;
        for (int k = 0; k < 3; k++) begin
            logic [4:0]  am;
            logic [31:0] dm;
            exp_t        e;
            am = (k == 2) ? 5'h1f : 5'h07;
            dm = (k == 2) ? 32'hffff_ffff : 32'h0000_ffff;
            e.chk = !rs;
            pred_port(k, int'(r1 & am), we, int'(wr & am), wd & dm, e.d1, e.b1);
            pred_port(k, int'(r2 & am), we, int'(wr & am), wd & dm, e.d2, e.b2);
            if (k == 0) q_a.push_back(e);
            else if (k == 1) q_b.push_back(e);
            else q_c.push_back(e);
            model_edge(k, rs, we, int'(wr & am), wd & dm, iv, int'(ir & am));
        end
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 1'b0, 5'd0, 32'h0, r1, r2, 1'b0, 5'd0);
    endtask

    task automatic wr_rd(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] r);
        step(1'b0, 1'b1, wa, wd, r, r, 1'b0, 5'd0);
    endtask

    task automatic cmp(input int k, input exp_t e, input logic [31:0] d1, input logic [31:0] d2,
                       input logic b1, input logic b2);
        vectors += 4;
        if (d1 !== e.d1) begin
            miscompares++;
            $display("FAIL inst%0d read_data_1: got %h want %h", k, d1, e.d1);
        end
        if (d2 !== e.d2) begin
            miscompares++;
            $display("FAIL inst%0d read_data_2: got %h want %h", k, d2, e.d2);
        end
        if (b1 !== e.b1) begin
            miscompares++;
            $display("FAIL inst%0d busy_1: got %b want %b", k, b1, e.b1);
        end
        if (b2 !== e.b2) begin
            miscompares++;
            $display("FAIL inst%0d busy_2: got %b want %b", k, b2, e.b2);
        end
    endtask

    // Monitor: one expected entry per instance per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            if (e.chk) cmp(0, e, {16'h0, if_a.read_data_1}, {16'h0, if_a.read_data_2},
                           if_a.busy_1, if_a.busy_2);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            if (e.chk) cmp(1, e, {16'h0, if_b.read_data_1}, {16'h0, if_b.read_data_2},
                           if_b.busy_1, if_b.busy_2);
        end
        if (q_c.size() > 0) begin
            e = q_c.pop_front();
            if (e.chk) cmp(2, e, if_c.read_data_1, if_c.read_data_2, if_c.busy_1, if_c.busy_2);
        end
    end

    initial begin
        rst = 1'b1;
        if_a.reg_write = 1'b0; if_a.write_reg = 3'd0; if_a.write_data = 16'h0;
        if_a.read_reg_1 = 3'd0; if_a.read_reg_2 = 3'd0; if_a.issue_valid = 1'b0; if_a.issue_reg = 3'd0;
        if_b.reg_write = 1'b0; if_b.write_reg = 3'd0; if_b.write_data = 16'h0;
        if_b.read_reg_1 = 3'd0; if_b.read_reg_2 = 3'd0; if_b.issue_valid = 1'b0; if_b.issue_reg = 3'd0;
        if_c.reg_write = 1'b0; if_c.write_reg = 5'd0; if_c.write_data = 32'h0;
        if_c.read_reg_1 = 5'd0; if_c.read_reg_2 = 5'd0; if_c.issue_valid = 1'b0; if_c.issue_reg = 5'd0;

        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);

        // Preload, mark busy, then reset: everything reads zero and idle.
        for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 5'(i), 32'h1111 * i, 5'd0, 5'd0, 1'b1, 5'(8 - i));
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 8; i++) rd(5'(i), 5'(7 - i));

        // Reset wins over a same-cycle write.
        step(1'b1, 1'b1, 5'd5, 32'h0000_BEEF, 5'd5, 5'd5, 1'b1, 5'd5);
        rd(5'd5, 5'd5);

        // Write every index, reading the same index in the write cycle and after.
        for (int i = 0; i < 8; i++) begin
            wr_rd(5'(i), 32'hA5A5 ^ i, 5'(i));
            rd(5'(i), 5'(i));
        end

        // Forwarding on port 2.
        wr_rd(5'd7, 32'h0, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h1234, 5'd1, 5'd7, 1'b0, 5'd0);
        rd(5'd1, 5'd7);

        // Busy scoreboard: issue, observe, write back, zero index.
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3);
        rd(5'd3, 5'd2);
        wr_rd(5'd3, 32'h3333, 5'd3);
        rd(5'd3, 5'd3);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
        rd(5'd0, 5'd0);

        // Issue and writeback of reg 4 together: stays busy, data updates.
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4);
        step(1'b0, 1'b1, 5'd4, 32'h5555, 5'd4, 5'd4, 1'b1, 5'd4);
        rd(5'd4, 5'd4);

        // Wide instance corners.
        wr_rd(5'd31, 32'hDEAD_BEEF, 5'd30);
        rd(5'd31, 5'd31);
        wr_rd(5'd0, 32'hFFFF_FFFF, 5'd0);
        rd(5'd0, 5'd0);

        // Random traffic with occasional mid-run resets.
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        #1;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries want 0", q_a.size() + q_b.size() + q_c.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
